// File: rtl/blinking_led_array.sv
// blinking_led_array
//   Memory-mapped bank of N_CH LED blinkers that sits in a CPU I/O slot and
//   drives board LEDs directly. A single prescaler produces a tick every
//   CLK_HZ/TICK_HZ clocks. Each channel toggles its phase after RATE ticks.
//   Each channel can be enabled, forced to a fixed level, and re-phased
//   through the SYNC register.
//
//   Register map (word addresses):
//     0..N_CH-1  RATE[i]  RW  half-period in ticks (CNT_W bits, 0 = stopped)
//     16         ENABLE   RW  per-channel blink enable (resets to all ones)
//     17         FORCE    RW  level driven while a channel is disabled
//     18         STATUS   RO  current led_out
//     19         SYNC     WO  bit i=1 restarts channel i low; reads 0
//     20/21      BRIGHT   RW  4-bit brightness, channels 0..7 / 8..15
//                             (only when LED_PWM_EN is defined)
//   Unmapped addresses and unimplemented bits read 0, and writes to them are ignored.
//
//   Optional feature macro: LED_PWM_EN adds the BRIGHT registers and a free
//   running 4-bit PWM counter that gates each LED with duty (BRIGHT+1)/16.
//
//   Ports:
//     clk      in   1      system clock
//     reset_n  in   1      asynchronous active-low reset
//     cs       in   1      slot select
//     read     in   1      read strobe, qualified by cs
//     write    in   1      write strobe, qualified by cs
//     addr     in   5      word address
//     wr_data  in   32     write data
//     rd_data  out  32     registered read data, held until the next read
//     led_out  out  N_CH   registered LED drive

module blinking_led_array #(
  parameter int N_CH    = 8,
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cs,
  input  logic            read,
  input  logic            write,
  input  logic [4:0]      addr,
  input  logic [31:0]     wr_data,
  output logic [31:0]     rd_data,
  output logic [N_CH-1:0] led_out
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;

  localparam logic [4:0]      ADDR_ENABLE    = 5'd16;
  localparam logic [4:0]      ADDR_FORCE     = 5'd17;
  localparam logic [4:0]      ADDR_STATUS    = 5'd18;
  localparam logic [4:0]      ADDR_SYNC      = 5'd19;
  localparam logic [PW-1:0]   PRESC_LAST     = PW'(DIV - 1);
  localparam logic [CNT_W:0]  CNT_ONE        = 1;

  if (DIV < 2) begin : gDivCheck
    $error("blinking_led_array: CLK_HZ/TICK_HZ must be at least 2");
  end
  if (N_CH < 1 || N_CH > 16) begin : gChCheck
    $error("blinking_led_array: N_CH must be in 1..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : gCntCheck
    $error("blinking_led_array: CNT_W must be in 1..32");
  end

  logic [CNT_W-1:0] rate_q  [N_CH];
  logic [CNT_W-1:0] rate_d  [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]  enable_q, enable_d;
  logic [N_CH-1:0]  force_q,  force_d;
  logic [N_CH-1:0]  phase_q,  phase_d;
  logic [N_CH-1:0]  ledOut_q, ledOut_d;
  logic [PW-1:0]    presc_q,  presc_d;
  logic [31:0]      rdData_q, rdData_d;
  logic [31:0]      rdMux;
  logic [N_CH-1:0]  level;
  logic [CNT_W:0]   cntInc;
  logic             tick;
  logic             wrEn;
  logic             rdEn;
  logic             unusedWrData;

`ifdef LED_PWM_EN
  localparam logic [4:0] ADDR_BRIGHT_LO = 5'd20;
  localparam logic [4:0] ADDR_BRIGHT_HI = 5'd21;

  logic [3:0] bright_q [N_CH];
  logic [3:0] bright_d [N_CH];
  logic [3:0] pwmCnt_q, pwmCnt_d;
`endif

  assign wrEn         = cs && write;
  assign rdEn         = cs && read;
  assign rd_data      = rdData_q;
  assign led_out      = ledOut_q;
  // Upper write-data bits are only meaningful for some registers.
  assign unusedWrData = ^wr_data;

  // Shared prescaler: one-cycle tick on the last count, then wrap.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Software-visible configuration registers.
  always_comb begin
    rate_d   = rate_q;
    enable_d = enable_q;
    force_d  = force_q;
    for (int i = 0; i < N_CH; i++) begin
      if (wrEn && (addr == 5'(i))) begin
        rate_d[i] = wr_data[CNT_W-1:0];
      end
    end
    if (wrEn && (addr == ADDR_ENABLE)) begin
      enable_d = wr_data[N_CH-1:0];
    end
    if (wrEn && (addr == ADDR_FORCE)) begin
      force_d = wr_data[N_CH-1:0];
    end
  end

  // Per-channel blink state. Priority: idle (disabled or rate 0) > SYNC >
  // RATE write > tick. The idle case keeps the channel cleared so it always
  // restarts low with a full half-period once it is re-enabled.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    cntInc  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cntInc = {1'b0, cnt_q[i]} + CNT_ONE;
      if (!enable_q[i] || (rate_q[i] == '0)) begin
        cnt_d[i]   = '0;
        phase_d[i] = 1'b0;
      end else if (wrEn && (addr == ADDR_SYNC) && wr_data[i]) begin
        cnt_d[i]   = '0;
        phase_d[i] = 1'b0;
      end else if (wrEn && (addr == 5'(i))) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cntInc >= {1'b0, rate_q[i]}) begin
          cnt_d[i]   = '0;
          phase_d[i] = ~phase_q[i];
        end else begin
          cnt_d[i] = cntInc[CNT_W-1:0];
        end
      end
    end
  end

`ifdef LED_PWM_EN
  // Brightness registers and the free-running PWM counter.
  always_comb begin
    bright_d = bright_q;
    pwmCnt_d = pwmCnt_q + 4'd1;
    for (int i = 0; i < N_CH; i++) begin
      if (wrEn && (addr == ((i < 8) ? ADDR_BRIGHT_LO : ADDR_BRIGHT_HI))) begin
        bright_d[i] = wr_data[4*(i%8) +: 4];
      end
    end
  end
`endif

  // LED level: blink phase when enabled, otherwise the forced level.
  always_comb begin
    level    = (enable_q & phase_q) | (~enable_q & force_q);
    ledOut_d = '0;
`ifdef LED_PWM_EN
    for (int i = 0; i < N_CH; i++) begin
      ledOut_d[i] = level[i] & (pwmCnt_q <= bright_q[i]);
    end
`else
    ledOut_d = level;
`endif
  end

  // Read mux uses pre-write register values, so a simultaneous read and
  // write returns the old contents.
  always_comb begin
    rdMux = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (addr == 5'(i)) begin
        rdMux = 32'(rate_q[i]);
      end
    end
    if (addr == ADDR_ENABLE) begin
      rdMux = 32'(enable_q);
    end
    if (addr == ADDR_FORCE) begin
      rdMux = 32'(force_q);
    end
    if (addr == ADDR_STATUS) begin
      rdMux = 32'(ledOut_q);
    end
`ifdef LED_PWM_EN
    for (int i = 0; i < N_CH; i++) begin
      if (addr == ((i < 8) ? ADDR_BRIGHT_LO : ADDR_BRIGHT_HI)) begin
        rdMux[4*(i%8) +: 4] = bright_q[i];
      end
    end
`endif
    rdData_d = rdEn ? rdMux : rdData_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        rate_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      enable_q <= '1;
      force_q  <= '0;
      phase_q  <= '0;
      ledOut_q <= '0;
      presc_q  <= '0;
      rdData_q <= '0;
    end else begin
      rate_q   <= rate_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
      force_q  <= force_d;
      phase_q  <= phase_d;
      ledOut_q <= ledOut_d;
      presc_q  <= presc_d;
      rdData_q <= rdData_d;
    end
  end

`ifdef LED_PWM_EN
  // Brightness state, reset to full duty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        bright_q[i] <= 4'hF;
      end
      pwmCnt_q <= '0;
    end else begin
      bright_q <= bright_d;
      pwmCnt_q <= pwmCnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_blinking_led_array.sv
// tb_blinking_led_array
//   Self-checking bench for blinking_led_array with N_CH=4, CLK_HZ=1000,
//   TICK_HZ=100 (10 clocks per tick). Register behaviour is exercised from a
//   vector table; blink timing, force, sync and reset are hand-written
//   sequences timed against a bench copy of the prescaler phase.

module tb_blinking_led_array;

  localparam int N_CH    = 4;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int CNT_W   = 16;
  localparam int DIV     = CLK_HZ / TICK_HZ;

`ifdef LED_PWM_EN
  localparam logic [31:0] ADDR20_EXP = 32'h0000_FFFF;
`else
  localparam logic [31:0] ADDR20_EXP = 32'h0000_0000;
`endif

  logic            clk     = 1'b0;
  logic            reset_n = 1'b0;
  logic            cs      = 1'b0;
  logic            read    = 1'b0;
  logic            write   = 1'b0;
  logic [4:0]      addr    = '0;
  logic [31:0]     wr_data = '0;
  logic [31:0]     rd_data;
  logic [N_CH-1:0] led_out;

  int errors     = 0;
  int checks     = 0;
  int prescModel = 0;

  typedef struct {
    string       name;
    logic [31:0] value;
  } expT;

  typedef struct {
    logic        doWrite;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expRead;
    string       name;
  } vecT;

  expT expQ[$];
  vecT vectors[$];

  blinking_led_array #(
    .N_CH    (N_CH),
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .CNT_W   (CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .read    (read),
    .write   (write),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .led_out (led_out)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Expected prescaler count, used to line writes up with tick boundaries.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) prescModel <= 0;
    else          prescModel <= (prescModel == DIV - 1) ? 0 : prescModel + 1;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkLed(input string name, input logic [N_CH-1:0] expected);
    checkOutput(name, 32'(led_out), 32'(expected));
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Returns just after the edge that leaves the prescaler at v, so the next
  // bus access lands on an edge whose pre-edge count is v.
  task automatic alignTo(input int v);
    for (int n = 0; n < 2 * DIV && prescModel != v; n++) stepCycle();
  endtask

  task automatic busWrite(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    stepCycle();
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic busRead(input logic [4:0] a, input string name,
                         input logic [31:0] expVal);
    expT e;
    e.name  = name;
    e.value = expVal;
    expQ.push_back(e);
    cs = 1'b1; read = 1'b1; addr = a;
    stepCycle();
    cs = 1'b0; read = 1'b0;
    e = expQ.pop_front();
    checkOutput(e.name, rd_data, e.value);
  endtask

  task automatic addVec(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] r, input string name);
    vecT v;
    v.doWrite = w; v.addr = a; v.wdata = d; v.expRead = r; v.name = name;
    vectors.push_back(v);
  endtask

  task automatic applyStimulus(input vecT v);
    if (v.doWrite) busWrite(v.addr, v.wdata);
    busRead(v.addr, v.name, v.expRead);
  endtask

  initial begin
    logic [N_CH-1:0] expLed;
    int              highCount;

    addVec(1'b1, 5'd3,  32'hABCD_1234, 32'h0000_1234, "RATE3 readback");
    addVec(1'b1, 5'd0,  32'h0000_0005, 32'h0000_0005, "RATE0 readback");
    addVec(1'b1, 5'd16, 32'hFFFF_FFF5, 32'h0000_0005, "ENABLE width");
    addVec(1'b1, 5'd17, 32'h0000_00FA, 32'h0000_000A, "FORCE width");
    addVec(1'b1, 5'd19, 32'h0000_000F, 32'h0000_0000, "SYNC reads 0");
    addVec(1'b1, 5'd25, 32'h0000_FFFF, 32'h0000_0000, "unmapped 25");
    addVec(1'b1, 5'd4,  32'h0000_0077, 32'h0000_0000, "unimplemented RATE4");
    addVec(1'b0, 5'd1,  32'h0000_0000, 32'h0000_0000, "RATE1 reset value");
    addVec(1'b1, 5'd1,  32'h0001_0000, 32'h0000_0000, "RATE1 upper bits");
    addVec(1'b1, 5'd20, 32'h0000_FFFF, ADDR20_EXP,    "addr 20");
    addVec(1'b1, 5'd2,  32'h0000_FFFF, 32'h0000_FFFF, "RATE2 max");

    // Reset state.
    applyReset();
    checkLed("reset led_out", '0);
    checkOutput("reset rd_data", rd_data, 32'h0);
    busRead(5'd16, "reset ENABLE", 32'hF);
    busRead(5'd17, "reset FORCE", 32'h0);
    busRead(5'd0, "reset RATE0", 32'h0);

    // Register table.
    for (int i = 0; i < vectors.size(); i++) applyStimulus(vectors[i]);

    // Simultaneous read and write returns the old FORCE value.
    cs = 1'b1; read = 1'b1; write = 1'b1; addr = 5'd17; wr_data = 32'h5;
    stepCycle();
    cs = 1'b0; read = 1'b0; write = 1'b0;
    checkOutput("rw collision pre-write", rd_data, 32'hA);
    busRead(5'd17, "rw collision written", 32'h5);

    // Blink: RATE[2]=3 written just after a tick, high 30 clocks later.
    applyReset();
    alignTo(0);
    busWrite(5'd2, 32'd3);
    for (int k = 1; k <= 90; k++) begin
      stepCycle();
      expLed = (((k / 30) % 2) == 1) ? 4'b0100 : 4'b0000;
      checkLed("blink ch2", expLed);
    end

    // Force while disabled, then re-enable starting low.
    applyReset();
    busWrite(5'd17, 32'h1);
    busWrite(5'd16, 32'hE);
    checkLed("force same edge", 4'b0000);
    stepCycle();
    checkLed("force next cycle", 4'b0001);
    busRead(5'd18, "STATUS readback", 32'h1);
    busWrite(5'd0, 32'd2);
    alignTo(0);
    busWrite(5'd16, 32'hF);
    checkLed("enable edge", 4'b0001);
    for (int k = 1; k <= 20; k++) begin
      stepCycle();
      expLed = (k == 20) ? 4'b0001 : 4'b0000;
      checkLed("enable restart", expLed);
    end
    cs = 1'b1; read = 1'b1; write = 1'b1; addr = 5'd17; wr_data = 32'h0;
    stepCycle();
    cs = 1'b0; read = 1'b0; write = 1'b0;
    checkOutput("force collision pre-write", rd_data, 32'h1);
    busRead(5'd17, "force after collision", 32'h0);

    // Sync two skewed channels.
    applyReset();
    alignTo(0);
    busWrite(5'd0, 32'd4);
    repeat (13) stepCycle();
    busWrite(5'd1, 32'd4);
    alignTo(0);
    busWrite(5'd19, 32'h3);
    for (int k = 1; k <= 85; k++) begin
      stepCycle();
      expLed = (((k / 40) % 2) == 1) ? 4'b0011 : 4'b0000;
      checkLed("sync ch0/ch1", expLed);
    end

    // SYNC on a tick edge suppresses the toggle.
    busWrite(5'd0, 32'd1);
    alignTo(0);
    busWrite(5'd19, 32'h1);
    alignTo(DIV - 1);
    busWrite(5'd19, 32'h1);
    for (int k = 1; k <= 11; k++) begin
      stepCycle();
      checkOutput("sync on tick ch0", 32'(led_out[0]), (k == 11) ? 32'h1 : 32'h0);
    end

    // Asynchronous reset in the middle of a high phase.
    applyReset();
    alignTo(0);
    busWrite(5'd0, 32'd2);
    repeat (25) stepCycle();
    checkLed("pre-reset blink", 4'b0001);
    busRead(5'd16, "pre-reset ENABLE", 32'hF);
    #3;
    reset_n = 1'b0;
    #1;
    checkLed("async reset led_out", 4'b0000);
    checkOutput("async reset rd_data", rd_data, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    busRead(5'd16, "post-reset ENABLE", 32'hF);
    busRead(5'd0, "post-reset RATE0", 32'h0);

`ifdef LED_PWM_EN
    // Forced LED at brightness 3: high 4 of every 16 clocks.
    busWrite(5'd17, 32'h1);
    busWrite(5'd16, 32'h0);
    busWrite(5'd20, 32'h3);
    repeat (4) stepCycle();
    highCount = 0;
    for (int k = 0; k < 32; k++) begin
      stepCycle();
      highCount += int'(led_out[0]);
    end
    checkOutput("pwm duty", 32'(highCount), 32'd8);
`else
    highCount = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
